// File: rtl/full_adder_4_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_4_pkg;

  // Operand and sum width used when the parent does not override it.
  localparam int DEFAULT_WIDTH = 4;

endpackage : full_adder_4_pkg

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder; a ripple chain of these forms the adder.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half;

  // Sum bit and carry out of this position.
  always_comb begin
    half = a ^ b;
    s    = half ^ cin;
    cout = (a & b) | (cin & half);
  end

endmodule : full_adder_bit

// File: rtl/full_adder_4.sv
// Registered WIDTH-bit ripple-carry adder with carry-in, carry-out and
// signed-overflow flag. Sum is computed combinationally and presented one
// cycle later from output flops.
module full_adder_4
  import full_adder_4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             overflow_next;

  assign carry[0] = carry_in;

  // Ripple chain: each bit consumes the carry produced by the bit below.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    full_adder_bit u_bit (
      .a    (data_a[gi]),
      .b    (data_b[gi]),
      .cin  (carry[gi]),
      .s    (sum[gi]),
      .cout (carry[gi+1])
    );
  end

  // Signed overflow: the carry into the sign bit disagrees with the carry out.
  assign overflow_next = carry[WIDTH-1] ^ carry[WIDTH];

  // Output registers: reset clears, accepted operands load, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out  <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      data_out  <= sum;
      carry_out <= carry[WIDTH];
      overflow  <= overflow_next;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule : full_adder_4

// File: tb/tb_full_adder_4.sv
// Self-checking bench for full_adder_4: directed table, exhaustive sweep,
// randomized stream against an arithmetic reference model, hand sequences.
module tb_full_adder_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] data_a;
  logic [3:0] data_b;
  logic       carry_in;
  logic [3:0] data_out;
  logic       carry_out;
  logic       overflow;
  logic       out_valid;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: what the outputs should show after the latest edge.
  int exp_sum = 0;
  int exp_cout = 0;
  int exp_ovf = 0;
  int exp_valid = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    int         sum;
    int         cout;
    int         ovf;
  } vec_t;

  vec_t vecs [4];

  full_adder_4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data_a    (data_a),
    .data_b    (data_b),
    .carry_in  (carry_in),
    .data_out  (data_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    tests_run++;
    if (got != want) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_all(input string tag, input int s, input int co,
                           input int ov, input int v);
    check({tag, " data_out"}, int'(data_out), s);
    check({tag, " carry_out"}, int'(carry_out), co);
    check({tag, " overflow"}, int'(overflow), ov);
    check({tag, " out_valid"}, int'(out_valid), v);
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic c);
    rst_n    = r;
    in_valid = v;
    data_a   = a;
    data_b   = b;
    carry_in = c;
  endtask

  // Advance one edge and move away from it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from plain integer arithmetic on the applied inputs.
  task automatic model(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic c);
    int full;
    int sa;
    int sb;
    int ss;
    if (!r) begin
      exp_sum = 0; exp_cout = 0; exp_ovf = 0; exp_valid = 0;
    end else if (v) begin
      full = int'(a) + int'(b) + int'(c);
      sa = (a >= 8) ? int'(a) - 16 : int'(a);
      sb = (b >= 8) ? int'(b) - 16 : int'(b);
      ss = sa + sb + int'(c);
      exp_sum   = full % 16;
      exp_cout  = full / 16;
      exp_ovf   = (ss > 7 || ss < -8) ? 1 : 0;
      exp_valid = 1;
    end else begin
      exp_valid = 0;
    end
  endtask

  initial begin
    vecs[0] = '{a: 4'hF, b: 4'h0, cin: 1'b1, sum: 0,  cout: 1, ovf: 0};
    vecs[1] = '{a: 4'hF, b: 4'hF, cin: 1'b1, sum: 15, cout: 1, ovf: 0};
    vecs[2] = '{a: 4'h7, b: 4'h1, cin: 1'b0, sum: 8,  cout: 0, ovf: 1};
    vecs[3] = '{a: 4'h8, b: 4'h8, cin: 1'b0, sum: 0,  cout: 1, ovf: 1};

    // Reset held for two edges with a valid all-ones operation presented.
    drive(1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
    step();
    step();
    check_all("reset", 0, 0, 0, 0);
    $display("[TB] reset: out=%0d co=%0d ov=%0d v=%0d", data_out, carry_out, overflow, out_valid);

    // Directed wrap/carry/overflow table, constants fixed by hand.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1);
      $display("[TB] vec%0d a=%h b=%h cin=%0d -> out=%h co=%0d ov=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, data_out, carry_out, overflow);
    end

    // Exhaustive sweep, back-to-back valid operations.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          drive(1'b1, 1'b1, 4'(a), 4'(b), 1'(c));
          model(1'b1, 1'b1, 4'(a), 4'(b), 1'(c));
          step();
          check_all($sformatf("exh a=%0d b=%0d c=%0d", a, b, c),
                    exp_sum, exp_cout, exp_ovf, exp_valid);
        end
      end
    end
    $display("[TB] exhaustive sweep done, %0d checks so far", tests_run);

    // Randomized stream with sparse valid and occasional reset.
    for (int i = 0; i < 200; i++) begin
      logic       r;
      logic       v;
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      r = ($urandom_range(0, 19) != 0);
      v = 1'($urandom_range(0, 1));
      a = 4'($urandom);
      b = 4'($urandom);
      c = 1'($urandom);
      drive(r, v, a, b, c);
      model(r, v, a, b, c);
      step();
      check_all($sformatf("rand%0d", i), exp_sum, exp_cout, exp_ovf, exp_valid);
    end
    $display("[TB] random stream done, %0d checks so far", tests_run);

    // Hold: accept 3+4, then idle with different operands applied.
    drive(1'b1, 1'b1, 4'd3, 4'd4, 1'b0);
    step();
    check_all("hold load", 7, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      step();
      check_all($sformatf("hold%0d", i), 7, 0, 0, 0);
    end
    $display("[TB] hold: out=%0d v=%0d", data_out, out_valid);

    // Reset mid-stream discards the operation sampled on the reset edge.
    drive(1'b1, 1'b1, 4'd1, 4'd1, 1'b0);
    step();
    check_all("stream0", 2, 0, 0, 1);
    drive(1'b1, 1'b1, 4'd5, 4'd6, 1'b1);
    step();
    check_all("stream1", 12, 0, 1, 1);
    drive(1'b0, 1'b1, 4'd9, 4'd9, 1'b1);
    step();
    check_all("midreset", 0, 0, 0, 0);
    drive(1'b1, 1'b1, 4'd2, 4'd2, 1'b1);
    step();
    check_all("after reset", 5, 0, 0, 1);
    $display("[TB] mid-stream reset: out=%0d v=%0d", data_out, out_valid);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_full_adder_4
